count_snapshot_uart: RTL and testbench



---
 rtl/count_uart_pkg.sv | 24 ++
 rtl/uart_tx_byte.sv | 108 ++++++++++
 rtl/count_snapshot_uart.sv | 96 +++++++++
 tb/tb_count_snapshot_uart.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_uart_pkg.sv
// ---------------------------------------------------------------------------
// count_uart_pkg
// Shared definitions for the count snapshot UART:
//   state_t          - serialiser states (IDLE, START, DATA, STOP)
//   DEF_CLKS_PER_BIT - default baud divider (115200 baud at 50 MHz)
//   num_bytes()      - number of 8-bit bytes needed to carry a w-bit value
// ---------------------------------------------------------------------------
package count_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int DEF_CLKS_PER_BIT = 434;

  // ceil(w/8)
  function automatic int num_bytes(input int w);
    return (w + 7) / 8;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// ---------------------------------------------------------------------------
// uart_tx_byte
// Sends one 8N1 byte (start bit, 8 data bits LSB first, stop bit), each bit
// held for CLKS_PER_BIT clocks.
//   clk, reset : system clock, synchronous active-high reset
//   data       : byte to send, taken on the edge where valid && ready
//   valid      : a byte is presented
//   ready      : can take a byte this edge (idle, or last cycle of stop bit)
//   tx         : serial line, registered, idles high
// Because ready is also high on the final stop-bit cycle, a byte offered
// there goes straight into a new start bit with no idle gap.
// ---------------------------------------------------------------------------
module uart_tx_byte
  import count_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [BW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (baud == LAST);
  assign ready   = (state == IDLE) || ((state == STOP) && bit_end);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud <= '0;
          if (valid) begin
            shreg <= data;
            tx    <= 1'b0;
            state <= START;
          end
        end

        START: begin
          if (bit_end) begin
            baud    <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              // shreg[0] is on the line; the next bit sits at [1]
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            baud <= '0;
            if (valid) begin
              shreg <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          baud  <= '0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/count_snapshot_uart.sv
// ---------------------------------------------------------------------------
// count_snapshot_uart
// Snapshots the counter chain's count on a capture request and sends it as
// 8N1 UART bytes, most-significant byte first.
//   clk, reset : system clock, synchronous active-high reset
//   count      : live count, sampled only on an accepted capture
//   capture    : level request, sampled every edge
//   tx         : UART serial output (registered, idles high)
//   busy       : high while the byte sequence is in flight
//   overrun    : one-cycle pulse after any edge with capture=1 while busy
// ---------------------------------------------------------------------------
module count_snapshot_uart
  import count_uart_pkg::*;
#(
  parameter int COUNT_WIDTH  = 16,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   capture,
  output logic                   tx,
  output logic                   busy,
  output logic                   overrun
);

  localparam int NUM_BYTES = num_bytes(COUNT_WIDTH);
  localparam int SNAP_W    = NUM_BYTES * 8;
  localparam int IW        = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IW-1:0] TOP_IDX = IW'(NUM_BYTES - 1);

  logic [SNAP_W-1:0] snap;
  logic [SNAP_W-1:0] count_ext;
  logic [SNAP_W-1:0] sel_src;
  logic [IW-1:0]     byte_idx;   // byte currently on the line
  logic [IW-1:0]     sel_idx;    // byte offered to the serialiser
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;

  assign count_ext = SNAP_W'(count);

  // The first byte must start on the capture edge itself, before snap is
  // loaded, so it comes straight from count. Later bytes come from snap,
  // one below the byte on the line.
  assign sel_src = busy ? snap : count_ext;
  assign sel_idx = busy ? (byte_idx - 1'b1) : TOP_IDX;

  always_comb begin
    byte_data = '0;
    for (int i = 0; i < NUM_BYTES; i++)
      if (sel_idx == IW'(i))
        byte_data = sel_src[i*8 +: 8];
  end

  // While busy, the next byte is offered continuously; the serialiser only
  // takes it on its last stop-bit cycle, giving back-to-back frames.
  assign byte_valid = busy ? (byte_idx != '0) : capture;

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .data (byte_data),
    .valid(byte_valid),
    .ready(byte_ready),
    .tx   (tx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      snap     <= '0;
      byte_idx <= '0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      overrun <= capture & busy;
      if (!busy) begin
        if (capture) begin
          snap     <= count_ext;
          byte_idx <= TOP_IDX;
          busy     <= 1'b1;
        end
      end else if (byte_ready) begin
        // ready while busy means the current byte's stop bit just ended;
        // capture is deliberately not looked at on this edge
        if (byte_idx != '0)
          byte_idx <= byte_idx - 1'b1;
        else
          busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_count_snapshot_uart.sv
// Bench for count_snapshot_uart: a 16-bit and a 12-bit instance, both with
// 4 clocks per bit. A reference model derives tx/busy/overrun from the time
// elapsed since the accepted capture; directed vectors decode whole frames.
module tb_count_snapshot_uart;

  localparam int C     = 4;
  localparam int FRAME = 2 * 10 * C;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  cap;
  logic [15:0] cnt [2];
  logic [1:0]  tx_o, busy_o, ovr_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  count_snapshot_uart #(.COUNT_WIDTH(16), .CLKS_PER_BIT(C)) d16 (
    .clk(clk), .reset(reset), .count(cnt[0]), .capture(cap[0]),
    .tx(tx_o[0]), .busy(busy_o[0]), .overrun(ovr_o[0]));

  count_snapshot_uart #(.COUNT_WIDTH(12), .CLKS_PER_BIT(C)) d12 (
    .clk(clk), .reset(reset), .count(cnt[1][11:0]), .capture(cap[1]),
    .tx(tx_o[1]), .busy(busy_o[1]), .overrun(ovr_o[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", nm, got, want, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mact [2];
  int          mt   [2];
  logic [15:0] msnap[2];
  logic        meovr[2];

  // line level t cycles after the accepted capture edge
  function automatic logic exp_tx(input logic [15:0] s, input int t);
    int b, k, p;
    logic [7:0] by;
    b  = t / C;
    k  = b / 10;
    p  = b % 10;
    by = (k == 0) ? s[15:8] : s[7:0];
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return by[p-1];
  endfunction

  always begin
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      meovr[d] = !reset && cap[d] && mact[d];
      if (reset) begin
        mact[d] = 1'b0;
        mt[d]   = 0;
      end else if (mact[d]) begin
        mt[d]++;
        if (mt[d] == FRAME) mact[d] = 1'b0;
      end else if (cap[d]) begin
        mact[d]  = 1'b1;
        mt[d]    = 0;
        msnap[d] = (d == 0) ? cnt[d] : (cnt[d] & 16'h0FFF);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("mon%0d_tx", d), 32'(tx_o[d]),
          32'(mact[d] ? exp_tx(msnap[d], mt[d]) : 1'b1));
      chk($sformatf("mon%0d_busy", d), 32'(busy_o[d]), 32'(mact[d]));
      chk($sformatf("mon%0d_overrun", d), 32'(ovr_o[d]), 32'(meovr[d]));
    end
  end

  // ---------------- directed helpers ----------------
  logic tx_s [300];
  logic busy_s [300];
  logic ovr_s [300];

  task automatic samp(input int d, input int i);
    tx_s[i]   = tx_o[d];
    busy_s[i] = busy_o[d];
    ovr_s[i]  = ovr_o[d];
  endtask

  // one-cycle capture of v, then n samples (sample 0 = cycle after capture edge)
  task automatic run_frame(input int d, input logic [15:0] v, input int n);
    @(negedge clk);
    cnt[d] = v;
    cap[d] = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      samp(d, i);
      cap[d] = 1'b0;
    end
  endtask

  // mid-bit decode of two frames starting at sample off
  task automatic decode(input int off, output logic [15:0] val, output int ferr);
    logic [7:0] by [2];
    ferr = 0;
    for (int k = 0; k < 2; k++) begin
      if (tx_s[off + (k*10)*C + C/2] !== 1'b0) ferr++;
      if (tx_s[off + (k*10+9)*C + C/2] !== 1'b1) ferr++;
      for (int i = 0; i < 8; i++)
        by[k][i] = tx_s[off + (k*10+1+i)*C + C/2];
    end
    val = {by[0], by[1]};
  endtask

  function automatic int nbusy(input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (busy_s[i] === 1'b1) n++;
    return n;
  endfunction

  typedef struct {
    int          d;
    logic [15:0] v;
    logic [15:0] want;
  } vec_t;

  initial begin
    vec_t        vt [7];
    logic [19:0] lit;
    logic [15:0] val, base;
    int          ferr, errs;

    reset  = 1'b1;
    cap    = '0;
    cnt[0] = '0;
    cnt[1] = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx_o), 32'h3);
    chk("reset_busy", 32'(busy_o), 32'h0);
    reset = 1'b0;

    // quiet line after reset
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_o !== 2'b11 || busy_o !== 2'b00 || ovr_o !== 2'b00) errs++;
    end
    chk("idle_quiet", errs, 0);

    // 0xA55A: exact bit sequence and busy length
    run_frame(0, 16'hA55A, 90);
    lit  = 20'b0101001011_0010110101;
    errs = 0;
    for (int k = 0; k < FRAME; k++) if (tx_s[k] !== lit[19 - k/C]) errs++;
    chk("a55a_bits", errs, 0);
    chk("a55a_busy_cycles", nbusy(0, 89), FRAME);
    chk("a55a_tx_after", 32'(tx_s[FRAME]), 1);
    chk("a55a_busy_after", 32'(busy_s[FRAME]), 0);

    // vector table
    vt[0] = '{0, 16'hA55A, 16'hA55A};
    vt[1] = '{1, 16'h0ABC, 16'h0ABC};
    vt[2] = '{0, 16'h0000, 16'h0000};
    vt[3] = '{0, 16'hFFFF, 16'hFFFF};
    vt[4] = '{1, 16'h0FFF, 16'h0FFF};
    vt[5] = '{1, 16'hF123, 16'h0123};
    vt[6] = '{0, 16'h8001, 16'h8001};
    for (int i = 0; i < 7; i++) begin
      run_frame(vt[i].d, vt[i].v, 90);
      decode(0, val, ferr);
      chk($sformatf("tbl%0d_value", i), 32'(val), 32'(vt[i].want));
      chk($sformatf("tbl%0d_framing", i), ferr, 0);
      chk($sformatf("tbl%0d_busy", i), nbusy(0, 89), FRAME);
      chk($sformatf("tbl%0d_idle_tx", i), 32'(tx_s[85]), 1);
    end

    // second capture 10 cycles into a frame
    @(negedge clk);
    cnt[0] = 16'h1234;
    cap[0] = 1'b1;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk);
      samp(0, i);
      cap[0] = (i == 9);
      cnt[0] = 16'($urandom);
    end
    errs = 0;
    for (int i = 0; i < 110; i++) if (ovr_s[i] === 1'b1) errs++;
    chk("ovr_pulses", errs, 1);
    chk("ovr_at_10", 32'(ovr_s[10]), 1);
    decode(0, val, ferr);
    chk("ovr_frame_value", 32'(val), 32'h1234);
    chk("ovr_frame_framing", ferr, 0);
    chk("ovr_no_second", nbusy(0, 109), FRAME);
    errs = 0;
    for (int i = FRAME; i < 110; i++) if (tx_s[i] !== 1'b1) errs++;
    chk("ovr_line_idle", errs, 0);

    // capture held high, count moving every cycle
    base = 16'($urandom);
    @(negedge clk);
    cnt[0] = base;
    cap[0] = 1'b1;
    for (int i = 0; i < 242; i++) begin
      @(negedge clk);
      samp(0, i);
      cnt[0] = base + 16'(i + 1);
    end
    cap[0] = 1'b0;
    chk("held_idle_cycles", 242 - nbusy(0, 241), 2);
    chk("held_gap1_tx", 32'(tx_s[80]), 1);
    chk("held_gap2_tx", 32'(tx_s[161]), 1);
    chk("held_seq2_busy", 32'(busy_s[81]), 1);
    decode(0, val, ferr);
    chk("held_seq1", 32'(val), 32'(base));
    decode(81, val, ferr);
    chk("held_seq2", 32'(val), 32'(base + 16'd81));
    decode(162, val, ferr);
    chk("held_seq3", 32'(val), 32'(base + 16'd162));
    repeat (10) @(negedge clk);

    // reset during byte 0, data bit 3
    @(negedge clk);
    cnt[0] = 16'hC3E1;
    cap[0] = 1'b1;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      samp(0, i);
      cap[0] = 1'b0;
      if (i == 17) reset = 1'b1;
    end
    chk("rst_pre_bit3", 32'(tx_s[16]), 0);
    chk("rst_pre_busy", 32'(busy_s[17]), 1);
    @(negedge clk);
    chk("rst_tx", 32'(tx_o[0]), 1);
    chk("rst_busy", 32'(busy_o[0]), 0);
    chk("rst_ovr", 32'(ovr_o[0]), 0);
    reset = 1'b0;
    run_frame(0, 16'h5A0F, 90);
    decode(0, val, ferr);
    chk("rst_after_value", 32'(val), 32'h5A0F);
    chk("rst_after_framing", ferr, 0);
    chk("rst_after_busy", nbusy(0, 89), FRAME);

    // random traffic on both instances, checked by the model
    for (int c = 0; c < 2500; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        cap[d] = ($urandom_range(0, 19) == 0);
        cnt[d] = 16'($urandom);
      end
      reset = ($urandom_range(0, 599) == 0);
    end
    reset = 1'b0;
    cap   = '0;
    repeat (100) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
